mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT, default 255, max cycles awaiting s_ack.
REQ-002 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have per-master ports, with prefix x = ifu|lsu: x_req  in  1  request; x_addr  in  ADDR_W  address; x_gnt  out  1  request accepted, one-cycle pulse; x_rvalid  out  1  completion pulse; x_rdata  out  DATA_W  read data; x_err  out  1  timeout flag, valid with x_rvalid.
REQ-004 SHALL have LSU-only ports: lsu_wen  in  1  write; lsu_wdata  in  DATA_W  write data; lsu_wmask  in  8  byte mask. IFU is read-only.
REQ-005 SHALL have memory-side ports: s_req  out  1  access active; s_addr  out  ADDR_W; s_wen  out  1; s_wdata  out  DATA_W; s_wmask  out  8; s_ack  in  1  access done; s_rdata  in  DATA_W.

Function
REQ-006 SHALL use FSM states IDLE, BUSY, RESP.
REQ-007 In IDLE, if any x_req is high, SHALL assert x_gnt combinationally in the same cycle for exactly one master, latch owner, addr, wen, wdata and wmask, and enter BUSY; otherwise SHALL stay in IDLE.
REQ-008 If both requests are high in IDLE, SHALL grant the master not granted last (round-robin via a last_grant register); a single requester is granted regardless of last_grant.
REQ-009 When IFU is granted, SHALL latch wen=0 and wmask=0.
REQ-010 In BUSY, SHALL drive s_req=1 with the latched fields, held stable, and count cycles in a timeout counter cleared on entry to BUSY.
REQ-011 In BUSY with s_ack=1, SHALL register s_rdata (0 for writes), set err=0, and enter RESP.
REQ-012 In BUSY, when the counter reaches TIMEOUT without s_ack, SHALL set rdata=0, set err=1, and enter RESP; if s_ack arrives in that same cycle, ack wins and err=0.
REQ-013 In RESP, SHALL pulse owner x_rvalid for one cycle with x_rdata/x_err, keep s_req=0, and return to IDLE.
REQ-014 Non-owner x_rvalid SHALL be 0; x_rdata and x_err SHALL be 0 whenever x_rvalid=0.
REQ-015 x_gnt SHALL never be asserted outside IDLE; requests in BUSY/RESP wait and are not queued.
REQ-016 A master deasserting x_req before x_gnt SHALL cause no transaction.
REQ-017 Latency: req/gnt at cycle 0 -> s_req cycles 1..k with ack in cycle k -> x_rvalid in cycle k+1; minimum 2 cycles.
REQ-018 Back-to-back: a new grant SHALL be possible in the IDLE cycle immediately after RESP.
REQ-019 s_ack outside BUSY SHALL be ignored.

Reset
REQ-020 rst SHALL force state=IDLE, counter=0, and all latched fields and rdata/err to 0.
REQ-021 rst SHALL set last_grant=LSU so IFU wins the first contention.
REQ-022 While rst=1, all outputs SHALL be 0.
REQ-023 rst mid-operation SHALL abandon the transaction with no x_rvalid, and s_req SHALL be 0 from the cycle after the reset edge.

Structure
REQ-024 FSM state encoding and master-ID encoding (IFU=0, LSU=1) SHALL live in a shared package; TIMEOUT SHALL remain a module parameter.
REQ-025 The round-robin select SHALL be one sub-module, rr_arb2 (2-input, last-grant input, one-hot grant output).
REQ-026 The memory side SHALL connect directly to the existing SRAM wrapper, and the IFU SHALL fetch only via this block.

Verification
REQ-027 Scenario: IFU-only read, addr 0x80000000, ack on 3rd BUSY cycle, s_rdata=0x00000413 -> ifu_gnt at cycle 0, ifu_rvalid at cycle 4, rdata 0x00000413, err 0.
REQ-028 Scenario: simultaneous req right after reset -> IFU granted first, LSU granted in the IDLE cycle after IFU RESP.
REQ-029 Scenario: LSU write, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> s_wen=1 with exact fields held for all BUSY cycles, lsu_rvalid with rdata 0.
REQ-030 Scenario: no ack, TIMEOUT=4 -> x_rvalid with err=1 and rdata=0 exactly 6 cycles after gnt.
REQ-031 Scenario: rst asserted during BUSY -> no x_rvalid, s_req=0 from the cycle after the reset edge, and the next simultaneous contention grants IFU.
REQ-032 Scenario: both masters continuously requesting for 10 transactions -> grants strictly alternate, with no gnt while BUSY/RESP.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the IFU/LSU memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    M_IFU = 1'b0,
    M_LSU = 1'b1
  } master_t;

  localparam int WMASK_W = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - IFU, LSU and memory-side signals of the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_arbiter_pkg::*;

  logic               ifu_req;
  logic [ADDR_W-1:0]  ifu_addr;
  logic               ifu_gnt;
  logic               ifu_rvalid;
  logic [DATA_W-1:0]  ifu_rdata;
  logic               ifu_err;

  logic               lsu_req;
  logic [ADDR_W-1:0]  lsu_addr;
  logic               lsu_wen;
  logic [DATA_W-1:0]  lsu_wdata;
  logic [WMASK_W-1:0] lsu_wmask;
  logic               lsu_gnt;
  logic               lsu_rvalid;
  logic [DATA_W-1:0]  lsu_rdata;
  logic               lsu_err;

  logic               s_req;
  logic [ADDR_W-1:0]  s_addr;
  logic               s_wen;
  logic [DATA_W-1:0]  s_wdata;
  logic [WMASK_W-1:0] s_wmask;
  logic               s_ack;
  logic [DATA_W-1:0]  s_rdata;

  // master: the requesters plus the SRAM wrapper; slave: the arbiter itself
  modport master (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output s_ack, s_rdata,
    input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
    input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    input  s_req, s_addr, s_wen, s_wdata, s_wmask
  );

  modport slave (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  s_ack, s_rdata,
    output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
    output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
    output s_req, s_addr, s_wen, s_wdata, s_wmask
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-input round-robin select, one-hot grant
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  master_t    last_grant,
  output logic [1:0] gnt
);

  // bit 0 is IFU, bit 1 is LSU; on contention the one not served last wins
  assign gnt[0] = req[0] & (~req[1] | (last_grant == M_LSU));
  assign gnt[1] = req[1] & (~req[0] | (last_grant == M_IFU));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter sharing one SRAM port between IFU and LSU
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t             state;
  master_t            owner;
  master_t            last_grant;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic               wen_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [WMASK_W-1:0] wmask_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  logic [1:0] arb_gnt;
  logic [1:0] gnt;
  logic       idle, busy, resp;
  logic       ifu_rv, lsu_rv;

  rr_arb2 u_rr (
    .req        ({bus.lsu_req, bus.ifu_req}),
    .last_grant (last_grant),
    .gnt        (arb_gnt)
  );

  // every output is forced low while rst is held, whatever the state register says
  assign idle = !rst && (state == ST_IDLE);
  assign busy = !rst && (state == ST_BUSY);
  assign resp = !rst && (state == ST_RESP);
  assign gnt  = idle ? arb_gnt : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= M_IFU;
      last_grant <= M_LSU;
      cnt        <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt[1]) begin
            owner      <= M_LSU;
            last_grant <= M_LSU;
            addr_q     <= bus.lsu_addr;
            wen_q      <= bus.lsu_wen;
            wdata_q    <= bus.lsu_wdata;
            wmask_q    <= bus.lsu_wmask;
            cnt        <= '0;
            state      <= ST_BUSY;
          end else if (gnt[0]) begin
            owner      <= M_IFU;
            last_grant <= M_IFU;
            addr_q     <= bus.ifu_addr;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cnt        <= '0;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // an ack landing on the timeout cycle still completes normally
          if (bus.s_ack) begin
            rdata_q <= wen_q ? '0 : bus.s_rdata;
            err_q   <= 1'b0;
            state   <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ifu_rv = resp && (owner == M_IFU);
  assign lsu_rv = resp && (owner == M_LSU);

  assign bus.ifu_gnt    = gnt[0];
  assign bus.lsu_gnt    = gnt[1];
  assign bus.ifu_rvalid = ifu_rv;
  assign bus.lsu_rvalid = lsu_rv;
  assign bus.ifu_rdata  = ifu_rv ? rdata_q : '0;
  assign bus.lsu_rdata  = lsu_rv ? rdata_q : '0;
  assign bus.ifu_err    = ifu_rv & err_q;
  assign bus.lsu_err    = lsu_rv & err_q;

  assign bus.s_req   = busy;
  assign bus.s_addr  = busy ? addr_q  : '0;
  assign bus.s_wen   = busy & wen_q;
  assign bus.s_wdata = busy ? wdata_q : '0;
  assign bus.s_wmask = busy ? wmask_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scenarios plus random traffic against a transaction-level model
module tb_mem_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int gnt_cyc[2] = '{-1, -1};
  int rv_cyc[2]  = '{-1, -1};
  int rv_count   = 0;
  int gnt_hist[$];

  bit          rnd_mode = 1'b0;
  int          ack_at   = 0;
  logic [31:0] rd_val   = '0;

  // Model: at most one transaction in flight; it completes on ack or after TO+1 memory cycles
  bit          m_active = 1'b0;
  bit          m_resp   = 1'b0;
  int          m_age    = 0;
  int          m_owner  = 0;
  int          m_last   = 1;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_wdata  = '0;
  logic [31:0] m_rd     = '0;
  logic [7:0]  m_wmask  = '0;
  logic        m_wen    = 1'b0;
  logic        m_err    = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin : monitor
    int          pick;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    cyc++;
    pick = -1;
    if (!rst && !m_active && !m_resp) begin
      if (bus.ifu_req && bus.lsu_req) pick = 1 - m_last;
      else if (bus.ifu_req)           pick = 0;
      else if (bus.lsu_req)           pick = 1;
    end
    e_gnt = (pick == 0) ? 2'b01 : (pick == 1) ? 2'b10 : 2'b00;
    e_rv  = (!rst && m_resp) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;

    chk("ifu_gnt", 64'(bus.ifu_gnt), 64'(e_gnt[0]));
    chk("lsu_gnt", 64'(bus.lsu_gnt), 64'(e_gnt[1]));
    chk("s_req", 64'(bus.s_req), 64'(!rst && m_active));
    if (rst) begin
      chk("s_addr_rst",  64'(bus.s_addr),  64'(0));
      chk("s_wen_rst",   64'(bus.s_wen),   64'(0));
      chk("s_wdata_rst", 64'(bus.s_wdata), 64'(0));
      chk("s_wmask_rst", 64'(bus.s_wmask), 64'(0));
    end else if (m_active) begin
      chk("s_addr",  64'(bus.s_addr),  64'(m_addr));
      chk("s_wen",   64'(bus.s_wen),   64'(m_wen));
      chk("s_wmask", 64'(bus.s_wmask), 64'(m_wmask));
      if (m_owner == 1) chk("s_wdata", 64'(bus.s_wdata), 64'(m_wdata));
    end
    chk("ifu_rvalid", 64'(bus.ifu_rvalid), 64'(e_rv[0]));
    chk("lsu_rvalid", 64'(bus.lsu_rvalid), 64'(e_rv[1]));
    chk("ifu_rdata",  64'(bus.ifu_rdata),  64'(e_rv[0] ? m_rd : 32'h0));
    chk("lsu_rdata",  64'(bus.lsu_rdata),  64'(e_rv[1] ? m_rd : 32'h0));
    chk("ifu_err",    64'(bus.ifu_err),    64'(e_rv[0] & m_err));
    chk("lsu_err",    64'(bus.lsu_err),    64'(e_rv[1] & m_err));

    if (bus.ifu_gnt) begin gnt_cyc[0] = cyc; gnt_hist.push_back(0); end
    if (bus.lsu_gnt) begin gnt_cyc[1] = cyc; gnt_hist.push_back(1); end
    if (bus.ifu_rvalid) begin rv_cyc[0] = cyc; rv_count++; end
    if (bus.lsu_rvalid) begin rv_cyc[1] = cyc; rv_count++; end

    if (rst) begin
      m_active = 1'b0;
      m_resp   = 1'b0;
      m_last   = 1;
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_active) begin
      m_age++;
      if (bus.s_ack) begin
        m_active = 1'b0; m_resp = 1'b1;
        m_rd = m_wen ? 32'h0 : bus.s_rdata; m_err = 1'b0;
      end else if (m_age == TO + 1) begin
        m_active = 1'b0; m_resp = 1'b1;
        m_rd = 32'h0; m_err = 1'b1;
      end
    end else if (pick >= 0) begin
      m_active = 1'b1; m_age = 0; m_owner = pick; m_last = pick;
      if (pick == 1) begin
        m_addr = bus.lsu_addr; m_wen = bus.lsu_wen;
        m_wdata = bus.lsu_wdata; m_wmask = bus.lsu_wmask;
      end else begin
        m_addr = bus.ifu_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
      end
    end
  end

  // SRAM stand-in: acks on the ack_at-th cycle of s_req (0 = never)
  initial begin : responder
    int bn;
    int cur;
    bn = 0;
    cur = 0;
    bus.s_ack = 1'b0;
    bus.s_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.s_req) begin
        bn++;
        if (bn == 1) cur = rnd_mode ? int'($urandom_range(0, 6)) : ack_at;
        bus.s_ack   = (cur != 0) && (bn == cur);
        bus.s_rdata = rnd_mode ? $urandom : rd_val;
      end else begin
        bn = 0;
        bus.s_ack   = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.s_rdata = $urandom;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rv(input int m);
    int c0;
    bit ok;
    c0 = rv_cyc[m];
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      sample();
      if (rv_cyc[m] != c0) ok = 1'b1;
    end
    chk("wait_rvalid_seen", 64'(ok), 64'(1));
  endtask

  task automatic wait_gnt(input int m);
    int c0;
    bit ok;
    c0 = gnt_cyc[m];
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      sample();
      if (gnt_cyc[m] != c0) ok = 1'b1;
    end
    chk("wait_gnt_seen", 64'(ok), 64'(1));
  endtask

  initial begin : main
    int rvc;
    int n0;
    bit done;
    bus.ifu_req = 1'b0; bus.ifu_addr = '0;
    bus.lsu_req = 1'b0; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // IFU read, ack on third memory cycle
    ack_at = 3; rd_val = 32'h0000_0413;
    bus.ifu_addr = 32'h8000_0000; bus.ifu_req = 1'b1;
    sample();
    chk("s1_ifu_gnt", 64'(bus.ifu_gnt), 64'(1));
    step();
    bus.ifu_req = 1'b0;
    wait_rv(0);
    chk("s1_latency", 64'(rv_cyc[0] - gnt_cyc[0]), 64'(4));
    chk("s1_rdata",   64'(bus.ifu_rdata), 64'(32'h0000_0413));
    chk("s1_err",     64'(bus.ifu_err),   64'(0));

    // contention right after reset: IFU first, LSU right after IFU's response
    step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    ack_at = 1; rd_val = 32'h1111_2222;
    bus.ifu_req = 1'b1; bus.ifu_addr = 32'h8000_0004;
    bus.lsu_req = 1'b1; bus.lsu_addr = 32'h8000_2000; bus.lsu_wen = 1'b0;
    sample();
    chk("s2_ifu_first", 64'(bus.ifu_gnt), 64'(1));
    chk("s2_lsu_waits", 64'(bus.lsu_gnt), 64'(0));
    step();
    bus.ifu_req = 1'b0;
    wait_gnt(1);
    chk("s2_min_latency", 64'(rv_cyc[0] - gnt_cyc[0]), 64'(2));
    chk("s2_lsu_after_resp", 64'(gnt_cyc[1] - rv_cyc[0]), 64'(1));
    step();
    bus.lsu_req = 1'b0;
    wait_rv(1);
    chk("s2_lsu_rdata", 64'(bus.lsu_rdata), 64'(32'h1111_2222));

    // LSU write: fields held through every memory cycle, completion carries no data
    step();
    ack_at = 3; rd_val = 32'hCAFE_F00D;
    bus.lsu_req = 1'b1; bus.lsu_wen = 1'b1; bus.lsu_addr = 32'h8000_1000;
    bus.lsu_wdata = 32'hDEAD_BEEF; bus.lsu_wmask = 8'h0F;
    sample();
    chk("s3_lsu_gnt", 64'(bus.lsu_gnt), 64'(1));
    step();
    bus.lsu_req = 1'b0; bus.lsu_wen = 1'b0; bus.lsu_addr = '0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("s3_s_req",   64'(bus.s_req),   64'(1));
      chk("s3_s_wen",   64'(bus.s_wen),   64'(1));
      chk("s3_s_addr",  64'(bus.s_addr),  64'(32'h8000_1000));
      chk("s3_s_wdata", 64'(bus.s_wdata), 64'(32'hDEAD_BEEF));
      chk("s3_s_wmask", 64'(bus.s_wmask), 64'(8'h0F));
    end
    wait_rv(1);
    chk("s3_rdata", 64'(bus.lsu_rdata), 64'(0));
    chk("s3_err",   64'(bus.lsu_err),   64'(0));

    // no ack: timeout response six cycles after the grant
    step();
    ack_at = 0; rd_val = 32'h5555_AAAA;
    bus.ifu_req = 1'b1; bus.ifu_addr = 32'h8000_0010;
    sample();
    chk("s4_ifu_gnt", 64'(bus.ifu_gnt), 64'(1));
    step();
    bus.ifu_req = 1'b0;
    wait_rv(0);
    chk("s4_latency", 64'(rv_cyc[0] - gnt_cyc[0]), 64'(6));
    chk("s4_err",     64'(bus.ifu_err),   64'(1));
    chk("s4_rdata",   64'(bus.ifu_rdata), 64'(0));

    // reset during an IFU access: abandoned, and IFU still wins the next contention
    step();
    bus.ifu_req = 1'b1; bus.ifu_addr = 32'h8000_0020;
    sample();
    chk("s5_ifu_gnt", 64'(bus.ifu_gnt), 64'(1));
    rvc = rv_count;
    step();
    bus.ifu_req = 1'b0;
    step();
    rst = 1'b1;
    sample();
    chk("s5_sreq_in_rst", 64'(bus.s_req), 64'(0));
    step();
    rst = 1'b0;
    sample();
    chk("s5_sreq_after_rst", 64'(bus.s_req), 64'(0));
    repeat (8) sample();
    chk("s5_no_rvalid", 64'(rv_count - rvc), 64'(0));
    step();
    ack_at = 2; rd_val = 32'h0BAD_F00D;
    bus.ifu_req = 1'b1; bus.lsu_req = 1'b1;
    sample();
    chk("s5_ifu_wins", 64'(bus.ifu_gnt), 64'(1));
    step();
    bus.ifu_req = 1'b0; bus.lsu_req = 1'b0;
    wait_rv(0);

    // both masters requesting continuously: grants alternate
    step();
    ack_at = 2;
    n0 = gnt_hist.size();
    bus.ifu_req = 1'b1; bus.lsu_req = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      sample();
      if (gnt_hist.size() - n0 >= 10) done = 1'b1;
    end
    chk("s6_ten_grants", 64'(done), 64'(1));
    step();
    bus.ifu_req = 1'b0; bus.lsu_req = 1'b0;
    for (int i = n0 + 1; i < gnt_hist.size(); i++)
      chk("s6_alternate", 64'(gnt_hist[i] != gnt_hist[i-1]), 64'(1));
    repeat (10) step();

    // random traffic, including early request drops, stray acks and occasional resets
    rnd_mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step();
      rst = ($urandom_range(0, 149) == 0);
      bus.ifu_req   = ($urandom_range(0, 3) != 0);
      bus.lsu_req   = ($urandom_range(0, 2) != 0);
      bus.ifu_addr  = $urandom;
      bus.lsu_addr  = $urandom;
      bus.lsu_wen   = 1'($urandom_range(0, 1));
      bus.lsu_wdata = $urandom;
      bus.lsu_wmask = 8'($urandom);
    end
    rnd_mode = 1'b0;
    step();
    rst = 1'b0; bus.ifu_req = 1'b0; bus.lsu_req = 1'b0;
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
